// File: rtl/l2_lru_stack_profiler.sv
// Shared per-set LRU stack tagged by source, with power-of-two associativity hit counters.
// Optional macro L2_PROF_SRC_CNT_EN adds per-source miss counters on src_miss_count.
module l2_lru_stack_profiler #(
  parameter int WAYS     = 16,
  parameter int SETS     = 512,
  parameter int NUM_SRC  = 4,
  parameter int COUNT_W  = 32,
  localparam int WAY_W   = $clog2(WAYS),
  localparam int SET_W   = $clog2(SETS),
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [SRC_W-1:0]           req_src,
  input  logic [SET_W-1:0]           req_set,
  input  logic [WAY_W:0]             req_pos,
  input  logic                       stat_clr,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic [WAY_W:0]             resp_dist,
  output logic                       resp_evict,
  output logic [SRC_W-1:0]           resp_evict_src,
  output logic [WAY_W*COUNT_W-1:0]   hit_count,
  output logic [COUNT_W-1:0]         miss_count,
  output logic [COUNT_W-1:0]         access_count
`ifdef L2_PROF_SRC_CNT_EN
  ,
  output logic [NUM_SRC*COUNT_W-1:0] src_miss_count
`endif
);

  // IDLE accept | SEARCH locate g | UPDATE shift down to g | RESP report + count
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_UPDATE, S_RESP} state_t;

  state_t             r_state;
  logic [SRC_W-1:0]   r_src;
  logic [SET_W-1:0]   r_set;
  logic [WAY_W:0]     r_pos;
  logic               r_hit;
  logic [WAY_W-1:0]   r_g;
  logic [WAY_W-1:0]   r_ptr;
  logic               r_ev_v;
  logic [SRC_W-1:0]   r_ev_s;
  logic               r_ent_v [SETS][WAYS];
  logic [SRC_W-1:0]   r_ent_s [SETS][WAYS];

  logic               r_req_ready;
  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [WAY_W:0]     r_resp_dist;
  logic               r_resp_evict;
  logic [SRC_W-1:0]   r_resp_evict_src;

  logic [COUNT_W-1:0] r_hit_cnt [WAY_W];
  logic [COUNT_W-1:0] r_miss_cnt;
  logic [COUNT_W-1:0] r_acc_cnt;

  logic               w_found;
  logic [WAY_W-1:0]   w_g;
  logic [WAY_W:0]     w_cnt;
  logic               w_hit;
  logic [WAY_W-1:0]   w_in_rng;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // g is the (pos+1)-th valid entry of this source, counted from the top
  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    w_cnt   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (r_ent_v[r_set][i] && (r_ent_s[r_set][i] == r_src)) begin
        if (!w_found && (w_cnt == r_pos)) begin
          w_found = 1'b1;
          w_g     = WAY_W'(i);
        end
        w_cnt = w_cnt + (WAY_W+1)'(1);
      end
    end
  end

  assign w_hit = w_found && (r_pos < (WAY_W+1)'(WAYS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_src            <= '0;
      r_set            <= '0;
      r_pos            <= '0;
      r_hit            <= 1'b0;
      r_g              <= '0;
      r_ptr            <= '0;
      r_ev_v           <= 1'b0;
      r_ev_s           <= '0;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_hit       <= 1'b0;
      r_resp_dist      <= '0;
      r_resp_evict     <= 1'b0;
      r_resp_evict_src <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_ent_v[s][w] <= 1'b0;
          r_ent_s[s][w] <= '0;
        end
      end
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_src       <= req_src;
            r_set       <= req_set;
            r_pos       <= req_pos;
            r_req_ready <= 1'b0;
            r_state     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          r_hit   <= w_hit;
          r_g     <= w_g;
          r_ptr   <= w_hit ? w_g : WAY_W'(WAYS - 1);
          r_ev_v  <= !w_hit && r_ent_v[r_set][WAYS-1];
          r_ev_s  <= w_hit ? '0 : r_ent_s[r_set][WAYS-1];
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (r_ptr != '0) begin
            r_ent_v[r_set][r_ptr] <= r_ent_v[r_set][r_ptr - WAY_W'(1)];
            r_ent_s[r_set][r_ptr] <= r_ent_s[r_set][r_ptr - WAY_W'(1)];
            r_ptr                 <= r_ptr - WAY_W'(1);
          end else begin
            r_ent_v[r_set][0] <= 1'b1;
            r_ent_s[r_set][0] <= r_src;
            r_state           <= S_RESP;
          end
        end
        default: begin
          r_resp_valid     <= 1'b1;
          r_resp_hit       <= r_hit;
          r_resp_dist      <= r_hit ? {1'b0, r_g} : (WAY_W+1)'(WAYS);
          r_resp_evict     <= r_ev_v;
          r_resp_evict_src <= r_ev_s;
          r_state          <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < WAY_W; k++) begin : g_slice
    assign w_in_rng[k] = ({1'b0, r_g} < (WAY_W+1)'(2 ** (k + 1)));
    assign hit_count[k*COUNT_W +: COUNT_W] = r_hit_cnt[k];
  end

`ifdef L2_PROF_SRC_CNT_EN
  logic [COUNT_W-1:0] r_src_miss [NUM_SRC];
  for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
    assign src_miss_count[n*COUNT_W +: COUNT_W] = r_src_miss[n];
  end
`endif

  // Clear takes priority over the increment on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WAY_W; k++) r_hit_cnt[k] <= '0;
      r_miss_cnt <= '0;
      r_acc_cnt  <= '0;
`ifdef L2_PROF_SRC_CNT_EN
      for (int n = 0; n < NUM_SRC; n++) r_src_miss[n] <= '0;
`endif
    end else if (stat_clr) begin
      for (int k = 0; k < WAY_W; k++) r_hit_cnt[k] <= '0;
      r_miss_cnt <= '0;
      r_acc_cnt  <= '0;
`ifdef L2_PROF_SRC_CNT_EN
      for (int n = 0; n < NUM_SRC; n++) r_src_miss[n] <= '0;
`endif
    end else if (r_state == S_RESP) begin
      r_acc_cnt <= sat_inc(r_acc_cnt);
      if (r_hit) begin
        for (int k = 0; k < WAY_W; k++) begin
          if (w_in_rng[k]) r_hit_cnt[k] <= sat_inc(r_hit_cnt[k]);
        end
      end else begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
`ifdef L2_PROF_SRC_CNT_EN
        r_src_miss[r_src] <= sat_inc(r_src_miss[r_src]);
`endif
      end
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_hit       = r_resp_hit;
  assign resp_dist      = r_resp_dist;
  assign resp_evict     = r_resp_evict;
  assign resp_evict_src = r_resp_evict_src;
  assign miss_count     = r_miss_cnt;
  assign access_count   = r_acc_cnt;

endmodule

// File: tb/tb_l2_lru_stack_profiler.sv
// Directed bench for l2_lru_stack_profiler (WAYS=4, SETS=4, NUM_SRC=2, COUNT_W=8).
module tb_l2_lru_stack_profiler;
  localparam int WAYS    = 4;
  localparam int SETS    = 4;
  localparam int NUM_SRC = 2;
  localparam int COUNT_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_src = 1'b0;
  logic [1:0]  req_set = '0;
  logic [2:0]  req_pos = '0;
  logic        stat_clr = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_hit;
  logic [2:0]  resp_dist;
  logic        resp_evict;
  logic        resp_evict_src;
  logic [15:0] hit_count;
  logic [7:0]  miss_count;
  logic [7:0]  access_count;
`ifdef L2_PROF_SRC_CNT_EN
  logic [15:0] src_miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l2_lru_stack_profiler #(
    .WAYS(WAYS), .SETS(SETS), .NUM_SRC(NUM_SRC), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_set(req_set), .req_pos(req_pos),
    .stat_clr(stat_clr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_dist(resp_dist),
    .resp_evict(resp_evict), .resp_evict_src(resp_evict_src),
    .hit_count(hit_count), .miss_count(miss_count), .access_count(access_count)
`ifdef L2_PROF_SRC_CNT_EN
    , .src_miss_count(src_miss_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic s, input logic [1:0] st, input logic [2:0] p);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1; req_src = s; req_set = st; req_pos = p;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Latency counts the handshake edge as edge 1
  task automatic wait_resp(output int lat);
    int n;
    n = 1;
    while (resp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    lat = n;
    chk("resp_seen", 32'(resp_valid), 1);
  endtask

  task automatic req(input string tag, input logic s, input logic [1:0] st, input logic [2:0] p,
                     input int lat_e, input logic h, input int d, input logic ev);
    int lat;
    start_req(s, st, p);
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(lat_e));
    chk({tag, "_hit"}, 32'(resp_hit), 32'(h));
    chk({tag, "_dist"}, 32'(resp_dist), 32'(d));
    chk({tag, "_evict"}, 32'(resp_evict), 32'(ev));
  endtask

  task automatic cnts(input string tag, input int hits, input int miss, input int acc);
    chk({tag, "_hits"}, 32'(hit_count), 32'(hits));
    chk({tag, "_miss"}, 32'(miss_count), 32'(miss));
    chk({tag, "_acc"}, 32'(access_count), 32'(acc));
  endtask

  initial begin
    int lat;
    logic seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(resp_valid), 0);
    cnts("rst", 0, 0, 0);

    // Fill set1 top-down to 1,0,1,0
    req("m1", 1'b0, 2'd1, 3'd0, 7, 1'b0, 4, 1'b0);
    cnts("m1", 0, 1, 1);
    req("m2", 1'b1, 2'd1, 3'd4, 7, 1'b0, 4, 1'b0);
    req("m3", 1'b0, 2'd1, 3'd4, 7, 1'b0, 4, 1'b0);
    req("m4", 1'b1, 2'd1, 3'd4, 7, 1'b0, 4, 1'b0);
    cnts("m4", 0, 4, 4);

    req("h3", 1'b0, 2'd1, 3'd1, 7, 1'b1, 3, 1'b0);
    cnts("h3", 16'h0100, 4, 5);
    req("h1", 1'b1, 2'd1, 3'd0, 5, 1'b1, 1, 1'b0);
    cnts("h1", 16'h0201, 4, 6);
    req("h0", 1'b1, 2'd1, 3'd0, 4, 1'b1, 0, 1'b0);
    cnts("h0", 16'h0302, 4, 7);

    // Forced misses on a full set: stack 1,0,0,1 -> 1,1,0,0 -> 0,1,1,0
    req("fm1", 1'b1, 2'd1, 3'd4, 7, 1'b0, 4, 1'b1);
    chk("fm1_evsrc", 32'(resp_evict_src), 1);
    cnts("fm1", 16'h0302, 5, 8);
    req("top1", 1'b1, 2'd1, 3'd0, 4, 1'b1, 0, 1'b0);
    req("fm0", 1'b0, 2'd1, 3'd4, 7, 1'b0, 4, 1'b1);
    chk("fm0_evsrc", 32'(resp_evict_src), 0);
    req("top0", 1'b1, 2'd1, 3'd0, 5, 1'b1, 1, 1'b0);
    cnts("top0", 16'h0504, 6, 11);

    // Private hit deeper than the source's shared occupancy is a miss
    req("s2a", 1'b1, 2'd2, 3'd4, 7, 1'b0, 4, 1'b0);
    req("s2b", 1'b1, 2'd2, 3'd1, 7, 1'b0, 4, 1'b0);
    cnts("s2", 16'h0504, 8, 13);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", 32'(resp_valid), 0);
    chk("hold_dist", 32'(resp_dist), 4);

    for (int i = 0; i < 300; i++) begin
      start_req(1'b0, 2'd3, 3'd4);
      wait_resp(lat);
    end
    cnts("sat", 16'h0504, 255, 255);

    // stat_clr coincident with the RESP edge
    start_req(1'b0, 2'd3, 3'd4);
    repeat (5) @(posedge clk);
    #1 stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("clr_valid", 32'(resp_valid), 1);
    cnts("clr", 0, 0, 0);
    req("pclr", 1'b0, 2'd3, 3'd4, 7, 1'b0, 4, 1'b1);
    cnts("pclr", 0, 1, 1);

    // Reset while UPDATE is shifting
    start_req(1'b0, 2'd1, 3'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("abort_noresp", 32'(seen), 0);
    chk("abort_ready", 32'(req_ready), 1);
    cnts("abort", 0, 0, 0);
    req("post", 1'b0, 2'd1, 3'd0, 7, 1'b0, 4, 1'b0);
    cnts("post", 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
